bnn_stream_tx: RTL and testbench
================================

# bnn_stream_tx

Serial stream transmitter that feeds the BNN input loader from the host or test side. It accepts a 28x28 binary image as 28 row words and eight 3x3 binary kernels as 9-bit words over valid/ready, buffers them, and shifts them out as two parallel serial bit streams (`d_out_p`, `d_out_w`) with a write-enable (`en_wr`). Bit ordering and enable alignment match the loader's fill order exactly, including its input pipeline latency.

## Interface

Parameters:
- `SYNC_LAT`, default 1: number of cycles the loader's input pipe delays serial data relative to `en_wr`. Legal range 0..3.

Ports:
- `clk`  in  1  clock
- `reset_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  single-cycle request to begin a frame; honoured only in IDLE
- `pix_row_valid`  in  1  pixel row word valid
- `pix_row_ready`  out  1  pixel row accepted when valid && ready
- `pix_row_data`  in  28  one image row; bit c = column c
- `wgt_valid`  in  1  kernel word valid
- `wgt_ready`  out  1  kernel accepted when valid && ready
- `wgt_data`  in  9  one kernel; bit t*3+b = kernel row t, bit b
- `d_out_p`  out  1  serial pixel bit to loader
- `d_out_w`  out  1  serial weight bit to loader
- `en_wr`  out  1  loader write enable
- `busy`  out  1  frame in progress
- `done`  out  1  one-cycle pulse at frame end

## Operation

- States: IDLE, LOAD, STREAM, DONE.
- IDLE: all handshake readies are 0. On `start`, go to LOAD and clear the row counter (0..28) and kernel counter (0..8).
- LOAD:
  - `pix_row_ready` = (row count < 28). Each handshake stores `pix_row_data` into buffer row `row_cnt`, then increments `row_cnt`.
  - `wgt_ready` = (kernel count < 8). Each handshake stores the kernel at index `k_cnt`, then increments `k_cnt`.
  - The two channels are independent and may transfer in the same cycle.
  - When both counts are full, go to STREAM with stream counter s = 0.
- STREAM: lasts exactly 784 + `SYNC_LAT` cycles, s = 0 .. 783+`SYNC_LAT`. In output cycle s:
  - `d_out_p` = pixel[s/28][s%28] for s < 784, else 0.
  - `d_out_w` = kernel[s/9] bit (s%9) for s < 72, else 0.
  - `en_wr` = 1 iff s >= `SYNC_LAT`.
  - Result: `en_wr` is high for exactly 784 consecutive cycles, and the loader samples pixel index i and weight index i on the i-th enable cycle.
- DONE: one cycle. `done` = 1, `en_wr` = 0. Then go to IDLE.
- `busy` = 1 in LOAD, STREAM and DONE; 0 in IDLE.
- The buffer holds 784 + 72 bits. It is not cleared between frames; each frame overwrites it fully.
- `start` is ignored outside IDLE. Valid words presented in IDLE or STREAM are not accepted (ready = 0); the sender holds them.

## Timing

- Reset values: all outputs 0, state IDLE, counters 0, buffer 0.
- Reset asserted mid-frame: abort immediately. `en_wr`, `d_out_*`, `busy` and `done` go to 0 asynchronously. The partial frame is discarded.
- All outputs are registered. `d_out_p`, `d_out_w` and `en_wr` change only on rising `clk`.
- `start` sampled in IDLE at edge N: readies are high from cycle N+1.
- Last LOAD handshake at edge M: STREAM output cycle s = 0 is driven from edge M+1.
- The last `en_wr` = 1 cycle is s = 783 + `SYNC_LAT`. `done` is high in the following cycle. The next `start` is accepted one cycle after `done`.
- Word transfers: at most one row and one kernel per cycle. Ready never depends combinationally on valid.
- Stream bit output: one bit per clock, no stalls. There is no backpressure from the loader.
- With `SYNC_LAT` = 0, `en_wr` is high from s = 0 and STREAM lasts 784 cycles.

## Test plan

- Reset, then `start`; send rows with row r = 1<<r (r < 28) and kernels k = 9'h1FF >> k. Capture `d_out_p`/`d_out_w` delayed by `SYNC_LAT` on `en_wr` cycles. Required: pixel bit r*28+r = 1 and all other pixel bits 0; the weight stream matches the kernel bits in k*9+t*3+b order; `en_wr` count = 784; `done` pulses once.
- Connect to the loader model with `SYNC_LAT` = 1 and random image/kernels. Required: loader `load_done` = 1 and its pixels/weights equal the sent words.
- Backpressure: hold `wgt_valid` = 0 until all 28 rows are sent, and send a 29th row. Required: `pix_row_ready` = 0 after 28 rows; STREAM starts only after the 8th kernel; the 29th row is not consumed.
- `start` pulsed during STREAM, and valid words presented in IDLE. Required: no restart, no extra handshakes, frame length unchanged at 784 + `SYNC_LAT` cycles.
- Assert `reset_n` = 0 at s = 400. Required: `en_wr`, `busy` and `d_out_*` = 0 immediately. After release and a new `start`, a full correct frame is sent.
- `SYNC_LAT` = 0 and `SYNC_LAT` = 3 builds: `en_wr` rises at s = 0 and s = 3 respectively. The first enabled sample equals pixel 0.

Source files
------------

// File: rtl/bnn_stream_tx.sv
// -----------------------------------------------------------------------------
// bnn_stream_tx
//
// Buffers one 28x28 binary image (28 row words) and eight 3x3 binary kernels
// (8 x 9-bit words), then serialises them into the BNN input loader as two
// parallel bit streams with a write enable. The enable is delayed by SYNC_LAT
// cycles relative to the data. This matches the delay of the loader's input
// pipe, so on its i-th enable cycle the loader samples pixel i and weight i.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 begin a frame (honoured only when idle)
//   pix_row_valid/ready   image row channel, pix_row_data[c] = column c
//   wgt_valid/ready       kernel channel, wgt_data[t*3+b] = kernel row t, bit b
//   d_out_p, d_out_w      serial pixel / weight bits to the loader
//   en_wr                 loader write enable
//   busy                  frame in progress (LOAD, STREAM, DONE)
//   done                  one-cycle pulse at frame end
//
// Handshake: a word transfers on a rising clk where valid && ready. Ready is a
// registered output and never looks at valid. The sender must hold valid and
// data stable until the transfer happens.
// -----------------------------------------------------------------------------
module bnn_stream_tx #(
  parameter int unsigned SYNC_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        pix_row_valid,
  output logic        pix_row_ready,
  input  logic [27:0] pix_row_data,
  input  logic        wgt_valid,
  output logic        wgt_ready,
  input  logic [8:0]  wgt_data,
  output logic        d_out_p,
  output logic        d_out_w,
  output logic        en_wr,
  output logic        busy,
  output logic        done
);

  localparam int unsigned N_PIX = 784;
  localparam int unsigned N_WGT = 72;

  // Last stream cycle index and the first cycle with the enable asserted.
  localparam logic [9:0] LAST_S = 10'(N_PIX - 1 + SYNC_LAT);
  localparam logic [9:0] LAT_S  = 10'(SYNC_LAT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       row_cnt_q, row_cnt_d;
  logic [3:0]       k_cnt_q, k_cnt_d;
  logic [9:0]       s_cnt_q, s_cnt_d;
  // Flat buffers: pixel (r,c) sits at bit r*28+c, weight (k,j) at bit k*9+j,
  // so the stream index s addresses both buffers directly.
  logic [N_PIX-1:0] pix_buf_q, pix_buf_d;
  logic [N_WGT-1:0] wgt_buf_q, wgt_buf_d;

  logic pix_row_ready_q, pix_row_ready_d;
  logic wgt_ready_q, wgt_ready_d;
  logic d_out_p_q, d_out_p_d;
  logic d_out_w_q, d_out_w_d;
  logic en_wr_q, en_wr_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic pix_hs;
  logic wgt_hs;

  assign pix_hs = pix_row_valid && pix_row_ready_q;
  assign wgt_hs = wgt_valid && wgt_ready_q;

  always_comb begin
    state_d         = state_q;
    row_cnt_d       = row_cnt_q;
    k_cnt_d         = k_cnt_q;
    s_cnt_d         = s_cnt_q;
    pix_buf_d       = pix_buf_q;
    wgt_buf_d       = wgt_buf_q;
    pix_row_ready_d = 1'b0;
    wgt_ready_d     = 1'b0;
    busy_d          = 1'b0;
    done_d          = 1'b0;
    d_out_p_d       = 1'b0;
    d_out_w_d       = 1'b0;
    en_wr_d         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d         = ST_LOAD;
          row_cnt_d       = 5'd0;
          k_cnt_d         = 4'd0;
          pix_row_ready_d = 1'b1;
          wgt_ready_d     = 1'b1;
          busy_d          = 1'b1;
        end
      end

      ST_LOAD: begin
        busy_d = 1'b1;
        if (pix_hs) begin
          pix_buf_d[10'(row_cnt_q) * 10'd28 +: 28] = pix_row_data;
          row_cnt_d = row_cnt_q + 5'd1;
        end
        if (wgt_hs) begin
          wgt_buf_d[7'(k_cnt_q) * 7'd9 +: 9] = wgt_data;
          k_cnt_d = k_cnt_q + 4'd1;
        end
        // Readies are registered from the post-handshake counts, so a channel
        // drops ready on the same edge that takes its last word.
        pix_row_ready_d = (row_cnt_d < 5'd28);
        wgt_ready_d     = (k_cnt_d < 4'd8);
        // Both buffers full: spend this edge launching stream cycle s = 0.
        if ((row_cnt_q == 5'd28) && (k_cnt_q == 4'd8)) begin
          state_d = ST_STREAM;
          s_cnt_d = 10'd0;
        end
      end

      ST_STREAM: begin
        busy_d = 1'b1;
        if (s_cnt_q == LAST_S) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          s_cnt_d = s_cnt_q + 10'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // s_cnt_q always names the stream cycle currently on the outputs. The
    // output flops are therefore loaded with the bits of s_cnt_d.
    if (state_d == ST_STREAM) begin
      d_out_p_d = (s_cnt_d < 10'd784) ? pix_buf_q[s_cnt_d] : 1'b0;
      d_out_w_d = (s_cnt_d < 10'd72) ? wgt_buf_q[s_cnt_d[6:0]] : 1'b0;
      en_wr_d   = (s_cnt_d >= LAT_S);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      row_cnt_q       <= 5'd0;
      k_cnt_q         <= 4'd0;
      s_cnt_q         <= 10'd0;
      pix_buf_q       <= '0;
      wgt_buf_q       <= '0;
      pix_row_ready_q <= 1'b0;
      wgt_ready_q     <= 1'b0;
      d_out_p_q       <= 1'b0;
      d_out_w_q       <= 1'b0;
      en_wr_q         <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      row_cnt_q       <= row_cnt_d;
      k_cnt_q         <= k_cnt_d;
      s_cnt_q         <= s_cnt_d;
      pix_buf_q       <= pix_buf_d;
      wgt_buf_q       <= wgt_buf_d;
      pix_row_ready_q <= pix_row_ready_d;
      wgt_ready_q     <= wgt_ready_d;
      d_out_p_q       <= d_out_p_d;
      d_out_w_q       <= d_out_w_d;
      en_wr_q         <= en_wr_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  assign pix_row_ready = pix_row_ready_q;
  assign wgt_ready     = wgt_ready_q;
  assign d_out_p       = d_out_p_q;
  assign d_out_w       = d_out_w_q;
  assign en_wr         = en_wr_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_bnn_stream_tx.sv
// -----------------------------------------------------------------------------
// tb_bnn_stream_tx
//
// Three transmitters (SYNC_LAT = 0, 1, 3) share one stimulus. Each has its own
// loader-side monitor. The monitor delays the serial bits by SYNC_LAT, collects
// them on enable cycles, and at done compares the frame with a reference image
// and kernel set built from the words that were sent.
// -----------------------------------------------------------------------------
module tb_bnn_stream_tx;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        pix_row_valid;
  logic [27:0] pix_row_data;
  logic        wgt_valid;
  logic [8:0]  wgt_data;

  logic prr  [3];
  logic wr   [3];
  logic d_p  [3];
  logic d_w  [3];
  logic en   [3];
  logic busy [3];
  logic done [3];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference frame: pixel (r,c) at r*28+c, weight (k,t,b) at k*9+t*3+b.
  logic [783:0] exp_pix;
  logic [71:0]  exp_w;
  logic [27:0]  rows  [28];
  logic [8:0]   kerns [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [783:0] got, input logic [783:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- DUTs + monitors
  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    localparam int L = (gi == 0) ? 0 : ((gi == 1) ? 1 : 3);

    bnn_stream_tx #(.SYNC_LAT(L)) u_dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .pix_row_valid (pix_row_valid),
      .pix_row_ready (prr[gi]),
      .pix_row_data  (pix_row_data),
      .wgt_valid     (wgt_valid),
      .wgt_ready     (wr[gi]),
      .wgt_data      (wgt_data),
      .d_out_p       (d_p[gi]),
      .d_out_w       (d_w[gi]),
      .en_wr         (en[gi]),
      .busy          (busy[gi]),
      .done          (done[gi])
    );

    logic [3:0]   hp, hw;
    logic [783:0] gp;
    logic [71:0]  gw;
    int           last_hs, first_en_s, last_en_s, en_cnt, rows_hs, k_hs;
    int           done_cnt = 0;
    bit           w_extra;

    always @(negedge clk) begin : mon
      int s;
      if (!reset_n) begin
        hp = '0; hw = '0; gp = '0; gw = '0;
        last_hs = -100000; first_en_s = -1; last_en_s = -1;
        en_cnt = 0; rows_hs = 0; k_hs = 0; w_extra = 1'b0;
      end else begin
        hp = {hp[2:0], d_p[gi]};
        hw = {hw[2:0], d_w[gi]};
        // Stream cycle index: s = 0 is the second cycle after the last handshake.
        s = cyc - last_hs - 2;
        if (en[gi]) begin
          if (en_cnt == 0) first_en_s = s;
          last_en_s = s;
          if (en_cnt < 784) gp[en_cnt] = hp[L];
          if (en_cnt < 72) gw[en_cnt] = hw[L];
          else if (hw[L]) w_extra = 1'b1;
          en_cnt++;
        end
        if (done[gi]) begin
          chk($sformatf("done_pos_L%0d", L), s, 784 + L);
          chk($sformatf("en_count_L%0d", L), en_cnt, 784);
          chk($sformatf("en_first_L%0d", L), first_en_s, L);
          chk($sformatf("en_last_L%0d", L), last_en_s, 783 + L);
          chk($sformatf("en_at_done_L%0d", L), en[gi], 0);
          chk($sformatf("pix_stream_L%0d", L), gp, exp_pix);
          chk($sformatf("wgt_stream_L%0d", L), gw, exp_w);
          chk($sformatf("wgt_tail_L%0d", L), w_extra, 0);
          chk($sformatf("row_hs_L%0d", L), rows_hs, 28);
          chk($sformatf("kern_hs_L%0d", L), k_hs, 8);
          done_cnt++;
          gp = '0; gw = '0; en_cnt = 0; rows_hs = 0; k_hs = 0;
          first_en_s = -1; last_en_s = -1; w_extra = 1'b0;
        end
        if (pix_row_valid && prr[gi]) begin rows_hs++; last_hs = cyc; end
        if (wgt_valid && wr[gi]) begin k_hs++; last_hs = cyc; end
      end
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic build_exp();
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++) exp_pix[r * 28 + c] = rows[r][c];
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 9; j++) exp_w[k * 9 + j] = kerns[k][j];
  endtask

  task automatic rand_data();
    for (int r = 0; r < 28; r++) rows[r] = 28'($urandom);
    for (int k = 0; k < 8; k++) kerns[k] = 9'($urandom);
    build_exp();
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_rows(input int max_gap);
    for (int r = 0; r < 28; r++) begin
      bit ok;
      int g;
      g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      pix_row_valid = 1'b0;
      repeat (g) begin @(posedge clk); #1; end
      pix_row_valid = 1'b1;
      pix_row_data  = rows[r];
      ok = 1'b0;
      for (int t = 0; t < 2000 && !ok; t++) begin
        @(negedge clk); ok = prr[1];
        @(posedge clk); #1;
      end
      chk("row_accept", ok, 1);
    end
    pix_row_valid = 1'b0;
  endtask

  task automatic send_kerns(input int max_gap);
    for (int k = 0; k < 8; k++) begin
      bit ok;
      int g;
      g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      wgt_valid = 1'b0;
      repeat (g) begin @(posedge clk); #1; end
      wgt_valid = 1'b1;
      wgt_data  = kerns[k];
      ok = 1'b0;
      for (int t = 0; t < 2000 && !ok; t++) begin
        @(negedge clk); ok = wr[1];
        @(posedge clk); #1;
      end
      chk("kern_accept", ok, 1);
    end
    wgt_valid = 1'b0;
  endtask

  task automatic send_words(input int max_gap);
    fork
      send_rows(max_gap);
      send_kerns(max_gap);
    join
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(negedge clk);
      ok = !busy[0] && !busy[1] && !busy[2];
    end
    chk("idle_timeout", ok, 1);
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string name);
    for (int i = 0; i < 3; i++)
      chk($sformatf("%s_%0d", name, i),
          {prr[i], wr[i], d_p[i], d_w[i], en[i], busy[i], done[i]}, 0);
  endtask

  // ---------------------------------------------------------------- test
  typedef struct {
    bit start;
    bit pv;
    bit wv;
    bit e_prr;
    bit e_wr;
    bit e_busy;
  } vec_t;

  vec_t tbl [5];

  initial begin
    tbl[0] = '{start:1'b0, pv:1'b1, wv:1'b1, e_prr:1'b0, e_wr:1'b0, e_busy:1'b0};
    tbl[1] = '{start:1'b0, pv:1'b0, wv:1'b1, e_prr:1'b0, e_wr:1'b0, e_busy:1'b0};
    tbl[2] = '{start:1'b1, pv:1'b0, wv:1'b0, e_prr:1'b1, e_wr:1'b1, e_busy:1'b1};
    tbl[3] = '{start:1'b1, pv:1'b0, wv:1'b0, e_prr:1'b1, e_wr:1'b1, e_busy:1'b1};
    tbl[4] = '{start:1'b0, pv:1'b0, wv:1'b0, e_prr:1'b1, e_wr:1'b1, e_busy:1'b1};

    reset_n = 1'b0; start = 1'b0;
    pix_row_valid = 1'b0; pix_row_data = '0;
    wgt_valid = 1'b0; wgt_data = '0;
    repeat (3) @(posedge clk); #1;
    chk_all_zero("reset_outs");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Idle behaviour and start; ends in LOAD with empty counters.
    for (int v = 0; v < 5; v++) begin
      start = tbl[v].start; pix_row_valid = tbl[v].pv; wgt_valid = tbl[v].wv;
      pix_row_data = 28'($urandom); wgt_data = 9'($urandom);
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("tbl%0d_prr_%0d", v, i), prr[i], tbl[v].e_prr);
        chk($sformatf("tbl%0d_wr_%0d", v, i), wr[i], tbl[v].e_wr);
        chk($sformatf("tbl%0d_busy_%0d", v, i), busy[i], tbl[v].e_busy);
        chk($sformatf("tbl%0d_done_%0d", v, i), done[i], 0);
      end
    end
    start = 1'b0; pix_row_valid = 1'b0; wgt_valid = 1'b0;

    // Frame 1: diagonal image, shifted all-ones kernels.
    for (int r = 0; r < 28; r++) rows[r] = 28'(1) << r;
    for (int k = 0; k < 8; k++) kerns[k] = 9'h1FF >> k;
    build_exp();
    send_words(0);
    wait_idle();

    // Frame 2: start and valid words presented during STREAM are ignored.
    rand_data();
    do_start();
    send_words(2);
    for (int t = 0; t < 6; t++) begin
      start = t[0]; pix_row_valid = 1'b1; wgt_valid = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) chk($sformatf("strm_ready_%0d", i), {prr[i], wr[i]}, 0);
      @(posedge clk); #1;
    end
    start = 1'b0; pix_row_valid = 1'b0; wgt_valid = 1'b0;
    wait_idle();

    // Frame 3: kernels held back, a 29th row is offered and must stay unused.
    rand_data();
    do_start();
    send_rows(1);
    pix_row_valid = 1'b1;
    pix_row_data  = 28'($urandom);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        chk($sformatf("bp_state_%0d", i), {prr[i], wr[i], en[i], busy[i]}, 4'b0101);
      @(posedge clk); #1;
    end
    send_kerns(1);
    wait_idle();
    pix_row_valid = 1'b0;

    // Frame 4: aborted by reset at stream cycle 400.
    rand_data();
    do_start();
    send_words(0);
    repeat (401) @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) chk($sformatf("en_mid_%0d", i), en[i], 1);
    reset_n = 1'b0;
    #1;
    chk_all_zero("abort_outs");
    repeat (2) @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Frames 5..8: full random frames with random handshake gaps.
    for (int f = 0; f < 4; f++) begin
      rand_data();
      do_start();
      send_words(f);
      wait_idle();
    end

    chk("done_count_L0", g_inst[0].done_cnt, 7);
    chk("done_count_L1", g_inst[1].done_cnt, 7);
    chk("done_count_L3", g_inst[2].done_cnt, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
